// File: rtl/battleship_pkg.sv
// rtl/battleship_pkg.sv - shared types, ship table and display constants for the shot scorer
package battleship_pkg;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_SCAN, S_REPORT, S_OVER} state_t;

  typedef enum logic [2:0] {
    SHIP_NONE, SHIP_CARRIER, SHIP_BATTLESHIP, SHIP_CRUISER,
    SHIP_SUBMARINE, SHIP_PATROL1, SHIP_PATROL2
  } ship_t;

  localparam int NUM_SHIP_CELLS = 19;

  localparam logic [4:0] CODE_NONE       = 5'b00000;
  localparam logic [4:0] CODE_CARRIER    = 5'b10000;
  localparam logic [4:0] CODE_BATTLESHIP = 5'b01000;
  localparam logic [4:0] CODE_CRUISER    = 5'b00100;
  localparam logic [4:0] CODE_SUBMARINE  = 5'b00010;
  localparam logic [4:0] CODE_PATROL     = 5'b00001;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    ship_t      ship;
  } ship_cell_t;

  localparam ship_cell_t SHIP_CELLS [NUM_SHIP_CELLS] = '{
    '{4'd2, 4'd3, SHIP_CARRIER}, '{4'd3, 4'd3, SHIP_CARRIER}, '{4'd4, 4'd3, SHIP_CARRIER},
    '{4'd5, 4'd3, SHIP_CARRIER}, '{4'd6, 4'd3, SHIP_CARRIER},
    '{4'd1, 4'd2, SHIP_BATTLESHIP}, '{4'd2, 4'd2, SHIP_BATTLESHIP},
    '{4'd3, 4'd2, SHIP_BATTLESHIP}, '{4'd4, 4'd2, SHIP_BATTLESHIP},
    '{4'd2, 4'd1, SHIP_CRUISER}, '{4'd3, 4'd1, SHIP_CRUISER}, '{4'd4, 4'd1, SHIP_CRUISER},
    '{4'd2, 4'd8, SHIP_SUBMARINE}, '{4'd2, 4'd9, SHIP_SUBMARINE}, '{4'd2, 4'd10, SHIP_SUBMARINE},
    '{4'd7, 4'd6, SHIP_PATROL1}, '{4'd8, 4'd6, SHIP_PATROL1},
    '{4'd9, 4'd1, SHIP_PATROL2}, '{4'd10, 4'd1, SHIP_PATROL2}
  };

  // Active-low segments, bit order gfedcba.
  localparam logic [6:0] SEG_0 = 7'b100_0000;
  localparam logic [6:0] SEG_1 = 7'b111_1001;
  localparam logic [6:0] SEG_2 = 7'b010_0100;
  localparam logic [6:0] SEG_3 = 7'b011_0000;
  localparam logic [6:0] SEG_4 = 7'b001_1001;
  localparam logic [6:0] SEG_5 = 7'b001_0010;
  localparam logic [6:0] SEG_6 = 7'b000_0010;
  localparam logic [6:0] SEG_7 = 7'b111_1000;
  localparam logic [6:0] SEG_8 = 7'b000_0000;
  localparam logic [6:0] SEG_9 = 7'b001_0000;

  function automatic ship_t ship_at(input int x, input int y);
    ship_t s;
    s = SHIP_NONE;
    for (int i = 0; i < NUM_SHIP_CELLS; i++)
      if (int'(SHIP_CELLS[i].x) == x && int'(SHIP_CELLS[i].y) == y) s = SHIP_CELLS[i].ship;
    return s;
  endfunction

  function automatic logic [4:0] ship_code(input ship_t s);
    case (s)
      SHIP_CARRIER:               return CODE_CARRIER;
      SHIP_BATTLESHIP:            return CODE_BATTLESHIP;
      SHIP_CRUISER:               return CODE_CRUISER;
      SHIP_SUBMARINE:             return CODE_SUBMARINE;
      SHIP_PATROL1, SHIP_PATROL2: return CODE_PATROL;
      default:                    return CODE_NONE;
    endcase
  endfunction

  function automatic logic [6:0] seg7(input logic [4:0] total);
    logic [4:0] d;
    d = (total >= 5'd10) ? total - 5'd10 : total;
    case (d)
      5'd0: return SEG_0;
      5'd1: return SEG_1;
      5'd2: return SEG_2;
      5'd3: return SEG_3;
      5'd4: return SEG_4;
      5'd5: return SEG_5;
      5'd6: return SEG_6;
      5'd7: return SEG_7;
      5'd8: return SEG_8;
      default: return SEG_9;
    endcase
  endfunction

endpackage

// File: rtl/battleship_cell_classifier.sv
// rtl/battleship_cell_classifier.sv - combinational ship / near-miss lookup for one board cell
module battleship_cell_classifier
  import battleship_pkg::*;
(
  input  logic [3:0] i_x,
  input  logic [3:0] i_y,
  output logic       o_is_ship,
  output logic       o_is_near,
  output ship_t      o_ship
);

  int w_x, w_y;

  always_comb begin
    w_x       = int'(i_x);
    w_y       = int'(i_y);
    o_ship    = ship_at(w_x, w_y);
    o_is_ship = (o_ship != SHIP_NONE);
    // Near means empty water sharing an edge with any ship cell.
    o_is_near = !o_is_ship &&
                ((ship_at(w_x - 1, w_y) != SHIP_NONE) || (ship_at(w_x + 1, w_y) != SHIP_NONE) ||
                 (ship_at(w_x, w_y - 1) != SHIP_NONE) || (ship_at(w_x, w_y + 1) != SHIP_NONE));
  end

endmodule

// File: rtl/battleship_shot_scorer.sv
// rtl/battleship_shot_scorer.sv - sequential Battleship shot scorer; optional ShipsSunk via BATTLESHIP_SUNK_REPORT_EN
module battleship_shot_scorer
  import battleship_pkg::*;
#(
  parameter int GRID_N    = 10,
  parameter int BIG_BOMBS = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic       Big,
  input  logic       ScoreThis,
  output logic       ready,
  output logic       done,
  output logic       Hit,
  output logic       NearMiss,
  output logic       Miss,
  output logic       SomethingIsWrong,
  output logic [4:0] TotalHits,
  output logic [4:0] BiggestShipHit,
  output logic [1:0] BigLeft,
  output logic [6:0] numHits,
  output logic       GameOver
`ifdef BATTLESHIP_SUNK_REPORT_EN
  ,
  output logic [5:0] ShipsSunk
`endif
);

  localparam logic [3:0] GRID_MAX  = 4'(GRID_N);
  localparam logic [4:0] GRID_MAX5 = 5'(GRID_N);
  localparam logic [4:0] ALL_HITS  = 5'(NUM_SHIP_CELLS);

  state_t       r_state, w_next;
  logic [3:0]   r_x, r_y;
  logic         r_big;
  logic [1:0]   r_col, r_row;
  logic [255:0] r_hit_map;
  logic         r_new_hit, r_near, r_wrong;
  logic [4:0]   r_work_total, r_work_biggest;

  logic [4:0]   w_sx, w_sy, w_code;
  logic [7:0]   w_map_idx;
  logic         w_on_grid, w_shot_valid, w_scan_last, w_is_ship, w_is_near;
  ship_t        w_ship;

  // Scan cell is centre + (col-1, row-1); five bits so the +1 edge never wraps.
  assign w_sx         = {1'b0, r_x} + {3'b000, r_col} - 5'd1;
  assign w_sy         = {1'b0, r_y} + {3'b000, r_row} - 5'd1;
  assign w_on_grid    = (w_sx != 5'd0) && (w_sx <= GRID_MAX5) && (w_sy != 5'd0) && (w_sy <= GRID_MAX5);
  assign w_map_idx    = {w_sy[3:0], w_sx[3:0]};
  assign w_shot_valid = (r_x != 4'd0) && (r_x <= GRID_MAX) && (r_y != 4'd0) && (r_y <= GRID_MAX) &&
                        !(r_big && BigLeft == 2'd0);
  assign w_scan_last  = !r_big || (r_col == 2'd2 && r_row == 2'd2);
  assign w_code       = ship_code(w_ship);

  battleship_cell_classifier u_classifier (
    .i_x       (w_sx[3:0]),
    .i_y       (w_sy[3:0]),
    .o_is_ship (w_is_ship),
    .o_is_near (w_is_near),
    .o_ship    (w_ship)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    ready    = 1'b0;
    GameOver = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (ScoreThis) w_next = S_CHECK;
      end
      S_CHECK:  w_next = w_shot_valid ? S_SCAN : S_REPORT;
      S_SCAN:   if (w_scan_last) w_next = S_REPORT;
      S_REPORT: w_next = (r_work_total == ALL_HITS) ? S_OVER : S_IDLE;
      S_OVER:   GameOver = 1'b1;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_x <= '0; r_y <= '0; r_big <= 1'b0; r_col <= '0; r_row <= '0;
      r_hit_map <= '0;
      r_new_hit <= 1'b0; r_near <= 1'b0; r_wrong <= 1'b0;
      r_work_total <= '0; r_work_biggest <= '0;
      done <= 1'b0; Hit <= 1'b0; NearMiss <= 1'b0; Miss <= 1'b0; SomethingIsWrong <= 1'b0;
      TotalHits <= '0; BiggestShipHit <= CODE_NONE; BigLeft <= 2'(BIG_BOMBS); numHits <= SEG_0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: if (ScoreThis) begin
          r_x <= X; r_y <= Y; r_big <= Big;
        end
        S_CHECK: begin
          r_new_hit      <= 1'b0;
          r_near         <= 1'b0;
          r_wrong        <= !w_shot_valid;
          r_col          <= r_big ? 2'd0 : 2'd1;
          r_row          <= r_big ? 2'd0 : 2'd1;
          r_work_total   <= TotalHits;
          r_work_biggest <= BiggestShipHit;
        end
        S_SCAN: begin
          if (w_on_grid) begin
            if (w_is_ship) begin
              if (!r_hit_map[w_map_idx]) begin
                r_hit_map[w_map_idx] <= 1'b1;
                r_new_hit <= 1'b1;
                if (r_work_total != ALL_HITS) r_work_total <= r_work_total + 5'd1;
                if (w_code > r_work_biggest) r_work_biggest <= w_code;
              end
            end else if (w_is_near) begin
              r_near <= 1'b1;
            end
          end
          if (r_col == 2'd2) begin
            r_col <= 2'd0;
            r_row <= r_row + 2'd1;
          end else begin
            r_col <= r_col + 2'd1;
          end
        end
        S_REPORT: begin
          done             <= 1'b1;
          SomethingIsWrong <= r_wrong;
          Hit              <= !r_wrong && r_new_hit;
          NearMiss         <= !r_wrong && !r_new_hit && r_near;
          Miss             <= !r_wrong && !r_new_hit && !r_near;
          TotalHits        <= r_work_total;
          BiggestShipHit   <= r_work_biggest;
          numHits          <= seg7(r_work_total);
          if (!r_wrong && r_big) BigLeft <= BigLeft - 2'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef BATTLESHIP_SUNK_REPORT_EN
  logic [5:0] w_sunk;

  always_comb begin
    w_sunk = 6'b111111;
    for (int i = 0; i < NUM_SHIP_CELLS; i++)
      if (!r_hit_map[{SHIP_CELLS[i].y, SHIP_CELLS[i].x}]) w_sunk[6 - int'(SHIP_CELLS[i].ship)] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                      ShipsSunk <= '0;
    else if (r_state == S_REPORT)   ShipsSunk <= ShipsSunk | w_sunk;
  end
`endif

endmodule

// File: tb/tb_battleship_shot_scorer.sv
// tb/tb_battleship_shot_scorer.sv - self-checking bench for battleship_shot_scorer
module tb_battleship_shot_scorer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] X = '0, Y = '0;
  logic       Big = 1'b0, ScoreThis = 1'b0;
  logic       ready, done, Hit, NearMiss, Miss, SomethingIsWrong, GameOver;
  logic [4:0] TotalHits, BiggestShipHit;
  logic [1:0] BigLeft;
  logic [6:0] numHits;
`ifdef BATTLESHIP_SUNK_REPORT_EN
  logic [5:0] ShipsSunk;
`endif

  battleship_shot_scorer dut (
    .clock(clock), .reset(reset), .X(X), .Y(Y), .Big(Big), .ScoreThis(ScoreThis),
    .ready(ready), .done(done), .Hit(Hit), .NearMiss(NearMiss), .Miss(Miss),
    .SomethingIsWrong(SomethingIsWrong), .TotalHits(TotalHits), .BiggestShipHit(BiggestShipHit),
    .BigLeft(BigLeft), .numHits(numHits), .GameOver(GameOver)
`ifdef BATTLESHIP_SUNK_REPORT_EN
    , .ShipsSunk(ShipsSunk)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int x, y, big, poke;
    int lat, hit, near, miss, wrong, total, biggest, left, over;
  } vec_t;

  vec_t vec [19];

  // Reference model state: plain per-cell hit array and counters.
  int mhit [16][16];
  int mtotal, mbiggest, mleft;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int seg_of(input int n);
    case (n % 10)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic int code_of(input int x, input int y);
    if (y == 3 && x >= 2 && x <= 6) return 16;
    if (y == 2 && x >= 1 && x <= 4) return 8;
    if (y == 1 && x >= 2 && x <= 4) return 4;
    if (x == 2 && y >= 8 && y <= 10) return 2;
    if (y == 6 && (x == 7 || x == 8)) return 1;
    if (y == 1 && (x == 9 || x == 10)) return 1;
    return 0;
  endfunction

  function automatic int near_of(input int x, input int y);
    return (code_of(x, y) == 0) &&
           (code_of(x - 1, y) != 0 || code_of(x + 1, y) != 0 ||
            code_of(x, y - 1) != 0 || code_of(x, y + 1) != 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) for (int j = 0; j < 16; j++) mhit[i][j] = 0;
    mtotal = 0; mbiggest = 0; mleft = 2;
  endtask

  task automatic model_shot(input int x, input int y, input int big, output vec_t e);
    int nh, nn, cx, cy, c;
    e.x = x; e.y = y; e.big = big; e.poke = 0;
    nh = 0; nn = 0;
    if (x < 1 || x > 10 || y < 1 || y > 10 || (big != 0 && mleft == 0)) begin
      e.lat = 2; e.wrong = 1; e.hit = 0; e.near = 0; e.miss = 0;
    end else begin
      for (int dy = -1; dy <= 1; dy++)
        for (int dx = -1; dx <= 1; dx++) begin
          if (big == 0 && (dx != 0 || dy != 0)) continue;
          cx = x + dx; cy = y + dy;
          if (cx < 1 || cx > 10 || cy < 1 || cy > 10) continue;
          c = code_of(cx, cy);
          if (c != 0) begin
            if (mhit[cx][cy] == 0) begin
              mhit[cx][cy] = 1; nh = 1;
              if (mtotal < 19) mtotal++;
              if (c > mbiggest) mbiggest = c;
            end
          end else if (near_of(cx, cy) != 0) nn = 1;
        end
      if (big != 0) mleft--;
      e.lat = (big != 0) ? 11 : 3; e.wrong = 0;
      e.hit = nh; e.near = (nh == 0 && nn != 0); e.miss = (nh == 0 && nn == 0);
    end
    e.total = mtotal; e.biggest = mbiggest; e.left = mleft; e.over = (mtotal == 19);
  endtask

  task automatic shot(input int x, input int y, input int big, input int poke, output int lat);
    @(negedge clock);
    X = x[3:0]; Y = y[3:0]; Big = (big != 0); ScoreThis = 1'b1;
    @(posedge clock); #1;
    ScoreThis = 1'b0;
    lat = -1;
    for (int c = 1; c <= 30; c++) begin
      ScoreThis = (poke != 0 && c >= 3 && c <= 5);
      @(posedge clock); #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    ScoreThis = 1'b0;
  endtask

  task automatic check_result(input string tag, input vec_t e, input int lat);
    chk({tag, " latency"}, lat, e.lat);
    chk({tag, " Hit"}, int'(Hit), e.hit);
    chk({tag, " NearMiss"}, int'(NearMiss), e.near);
    chk({tag, " Miss"}, int'(Miss), e.miss);
    chk({tag, " SomethingIsWrong"}, int'(SomethingIsWrong), e.wrong);
    chk({tag, " TotalHits"}, int'(TotalHits), e.total);
    chk({tag, " BiggestShipHit"}, int'(BiggestShipHit), e.biggest);
    chk({tag, " BigLeft"}, int'(BigLeft), e.left);
    chk({tag, " numHits"}, int'(numHits), seg_of(e.total));
    chk({tag, " GameOver"}, int'(GameOver), e.over);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " ready"}, int'(ready), 1);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " flags"}, int'({Hit, NearMiss, Miss, SomethingIsWrong}), 0);
    chk({tag, " TotalHits"}, int'(TotalHits), 0);
    chk({tag, " BiggestShipHit"}, int'(BiggestShipHit), 0);
    chk({tag, " BigLeft"}, int'(BigLeft), 2);
    chk({tag, " numHits"}, int'(numHits), 7'b1000000);
    chk({tag, " GameOver"}, int'(GameOver), 0);
  endtask

  task automatic do_reset();
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ndone;
    vec_t e;

    // x, y, big, poke, lat, hit, near, miss, wrong, total, biggest, left, over
    vec[0]  = '{3, 3, 0, 0, 3, 1, 0, 0, 0, 1, 16, 2, 0};
    vec[1]  = '{3, 3, 0, 0, 3, 0, 0, 1, 0, 1, 16, 2, 0};
    vec[2]  = '{0, 5, 0, 0, 2, 0, 0, 0, 1, 1, 16, 2, 0};
    vec[3]  = '{11, 2, 0, 0, 2, 0, 0, 0, 1, 1, 16, 2, 0};
    vec[4]  = '{3, 2, 1, 0, 11, 1, 0, 0, 0, 9, 16, 1, 0};
    vec[5]  = '{5, 5, 0, 0, 3, 0, 0, 1, 0, 9, 16, 1, 0};
    vec[6]  = '{5, 4, 0, 0, 3, 0, 1, 0, 0, 9, 16, 1, 0};
    vec[7]  = '{10, 10, 1, 1, 11, 0, 0, 1, 0, 9, 16, 0, 0};
    vec[8]  = '{5, 5, 1, 0, 2, 0, 0, 0, 1, 9, 16, 0, 0};
    vec[9]  = '{1, 2, 0, 0, 3, 1, 0, 0, 0, 10, 16, 0, 0};
    vec[10] = '{2, 8, 0, 0, 3, 1, 0, 0, 0, 11, 16, 0, 0};
    vec[11] = '{2, 9, 0, 0, 3, 1, 0, 0, 0, 12, 16, 0, 0};
    vec[12] = '{2, 10, 0, 0, 3, 1, 0, 0, 0, 13, 16, 0, 0};
    vec[13] = '{7, 6, 0, 0, 3, 1, 0, 0, 0, 14, 16, 0, 0};
    vec[14] = '{8, 6, 0, 0, 3, 1, 0, 0, 0, 15, 16, 0, 0};
    vec[15] = '{9, 1, 0, 0, 3, 1, 0, 0, 0, 16, 16, 0, 0};
    vec[16] = '{10, 1, 0, 0, 3, 1, 0, 0, 0, 17, 16, 0, 0};
    vec[17] = '{5, 3, 0, 0, 3, 1, 0, 0, 0, 18, 16, 0, 0};
    vec[18] = '{6, 3, 0, 0, 3, 1, 0, 0, 0, 19, 16, 0, 1};

    do_reset();
    check_reset_state("reset");

    for (int i = 0; i < 19; i++) begin
      shot(vec[i].x, vec[i].y, vec[i].big, vec[i].poke, lat);
      check_result($sformatf("vec%0d", i), vec[i], lat);
      if (vec[i].poke != 0) begin
        ndone = 0;
        repeat (14) begin @(posedge clock); #1; if (done) ndone++; end
        chk($sformatf("vec%0d extra done", i), ndone, 0);
      end
    end

    chk("over ready", int'(ready), 0);
    @(negedge clock); X = 4'd1; Y = 4'd1; Big = 1'b0; ScoreThis = 1'b1;
    ndone = 0;
    repeat (15) begin @(posedge clock); #1; if (done) ndone++; end
    ScoreThis = 1'b0;
    chk("over ignores shots", ndone, 0);
    chk("over GameOver held", int'(GameOver), 1);

    do_reset();
    check_reset_state("after over");

    @(negedge clock); X = 4'd3; Y = 4'd2; Big = 1'b1; ScoreThis = 1'b1;
    @(posedge clock); #1; ScoreThis = 1'b0;
    repeat (5) @(posedge clock);
    #2 reset = 1'b1;
    #1 check_reset_state("mid-scan reset");
    @(negedge clock); reset = 1'b0;
    #1 check_reset_state("mid-scan release");
    model_reset();
    model_shot(3, 2, 1, e);
    shot(3, 2, 1, 0, lat);
    check_result("rebig", e, lat);

    do_reset();
    model_reset();
    for (int i = 0; i < 40; i++) begin
      int rx, ry, rb;
      rx = $urandom_range(0, 12);
      ry = $urandom_range(0, 12);
      rb = ($urandom_range(0, 3) == 0) ? 1 : 0;
      model_shot(rx, ry, rb, e);
      shot(rx, ry, rb, 0, lat);
      check_result($sformatf("rand%0d (%0d,%0d,%0d)", i, rx, ry, rb), e, lat);
      if (e.over != 0) break;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
